// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
// The master side supplies operands and start; the slave side returns
// status and the registered result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             ov;

  modport master (
    output start, a, b,
    input  busy, done, d, bo, ov
  );

  modport slave (
    input  start, a, b,
    output busy, done, d, bo, ov
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor d = a - b.
// A single full_subtractor cell is fed one bit pair per clock, LSB first;
// its borrow-out is registered and fed back as the next bit's borrow-in.
// Result, final borrow and signed overflow are published on a one-cycle
// done pulse and held until the next operation completes.

// One-bit full subtractor: d = a - b - bi, bo = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;

  // Operand shift registers: bit 0 is the bit currently fed to the cell.
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  // Partial difference; the cell's current bit is prepended to form the
  // full-width value, so only WIDTH-1 bits need storing between cycles.
  logic [WIDTH-2:0] result_sr_reg;
  logic             borrow_reg;
  logic [CNT_W-1:0] count_reg;
  // Operand sign bits are kept aside because shifting consumes them.
  logic             a_msb_reg;
  logic             b_msb_reg;

  logic [WIDTH-1:0] d_reg;
  logic             bo_reg;
  logic             ov_reg;

  logic             cell_d;
  logic             cell_bo;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] result_full;

  full_subtractor u_cell (
    .a  (a_sr_reg[0]),
    .b  (b_sr_reg[0]),
    .bi (borrow_reg),
    .d  (cell_d),
    .bo (cell_bo)
  );

  assign result_full = {cell_d, result_sr_reg};
  assign last_bit    = (count_reg == CNT_W'(WIDTH - 1));

  // Next-state logic and handshake outputs; operands are accepted only
  // when not busy, which also covers back-to-back starts from DONE.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        bus.busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        if (bus.start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register plus serial datapath; outputs load only on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_sr_reg      <= '0;
      b_sr_reg      <= '0;
      result_sr_reg <= '0;
      borrow_reg    <= 1'b0;
      count_reg     <= '0;
      a_msb_reg     <= 1'b0;
      b_msb_reg     <= 1'b0;
      d_reg         <= '0;
      bo_reg        <= 1'b0;
      ov_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_sr_reg      <= bus.a;
        b_sr_reg      <= bus.b;
        a_msb_reg     <= bus.a[WIDTH-1];
        b_msb_reg     <= bus.b[WIDTH-1];
        result_sr_reg <= '0;
        borrow_reg    <= 1'b0;
        count_reg     <= '0;
      end else if (state_reg == SHIFT) begin
        a_sr_reg      <= a_sr_reg >> 1;
        b_sr_reg      <= b_sr_reg >> 1;
        result_sr_reg <= result_full[WIDTH-1:1];
        borrow_reg    <= cell_bo;
        count_reg     <= count_reg + CNT_W'(1);
        if (last_bit) begin
          d_reg  <= result_full;
          bo_reg <= cell_bo;
          // Signed overflow: operand signs differ and result sign left a's.
          ov_reg <= (a_msb_reg != b_msb_reg) && (cell_d != a_msb_reg);
        end
      end
    end
  end

  assign bus.d  = d_reg;
  assign bus.bo = bo_reg;
  assign bus.ov = ov_reg;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: an 8-bit instance for the
// directed scenarios and a 4-bit instance for the exhaustive sweep.
// Expected results are queued when an operation is launched and popped
// when the corresponding done pulse appears.
module tb_serial_subtractor;
  logic clk;
  logic rst;
  logic rst4;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp8_t;

  typedef struct packed {
    logic [3:0] d;
    logic       bo;
    logic       ov;
  } exp4_t;

  exp8_t exp8_q[$];
  exp4_t exp4_q[$];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: modular difference, unsigned borrow, signed range overflow.
  function automatic exp8_t ref8(input logic [7:0] a, input logic [7:0] b);
    exp8_t r;
    logic signed [7:0] sa;
    logic signed [7:0] sb;
    int sd;
    sa = a;
    sb = b;
    sd = int'(sa) - int'(sb);
    r.d  = a - b;
    r.bo = (a < b);
    r.ov = (sd > 127) || (sd < -128);
    return r;
  endfunction

  function automatic exp4_t ref4(input int a, input int b);
    exp4_t r;
    int sa;
    int sb;
    int sd;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    sd = sa - sb;
    r.d  = 4'((a - b) & 15);
    r.bo = (a < b);
    r.ov = (sd > 7) || (sd < -8);
    return r;
  endfunction

  // Launch an 8-bit op at the current negedge; returns one negedge later
  // with start released.
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b);
    bus8.a     = a;
    bus8.b     = b;
    bus8.start = 1'b1;
    exp8_q.push_back(ref8(a, b));
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  // Count negedges (the current one is 1) until done, bounded.
  task automatic wait_done8(output int n, output int nbusy, output bit ok);
    n     = 0;
    nbusy = 0;
    ok    = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (bus8.done === 1'b1) begin
        n  = k;
        ok = 1'b1;
        break;
      end
      if (bus8.busy === 1'b1) nbusy++;
    end
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    rst4 = 1'b1;
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    rst4 = 1'b0;
    bus8.a     = 8'h55;
    bus8.b     = 8'h11;
    bus8.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({bus8.busy, bus8.done, bus8.d, bus8.bo, bus8.ov} !== 12'h000) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: busy=%b done=%b d=%h bo=%b ov=%b, required all zero",
                 i, bus8.busy, bus8.done, bus8.d, bus8.bo, bus8.ov);
      end
    end
    checks++;
    if ({bus4.busy, bus4.done, bus4.d, bus4.bo, bus4.ov} !== 8'h00) begin
      errors++;
      $display("FAIL reset_w4: busy=%b done=%b d=%h bo=%b ov=%b, required all zero",
               bus4.busy, bus4.done, bus4.d, bus4.bo, bus4.ov);
    end
  endtask

  task automatic test_basic;
    int n;
    int nbusy;
    bit ok;
    exp8_t e;
    start_op8(8'd100, 8'd37);
    wait_done8(n, nbusy, ok);
    checks++;
    if (!ok || n != 9 || nbusy != 8) begin
      errors++;
      $display("FAIL basic_latency: done at %0d (found=%0b) busy cycles %0d, required done at 9 with busy 8",
               n, ok, nbusy);
    end
    e = exp8_q.pop_front();
    checks++;
    if ({bus8.d, bus8.bo, bus8.ov} !== {e.d, e.bo, e.ov}) begin
      errors++;
      $display("FAIL basic_result: d=%0d bo=%b ov=%b, required d=%0d bo=%b ov=%b",
               bus8.d, bus8.bo, bus8.ov, e.d, e.bo, e.ov);
    end
    @(negedge clk);
    checks++;
    if (bus8.done !== 1'b0 || bus8.d !== 8'd63) begin
      errors++;
      $display("FAIL basic_done_width: done=%b d=%0d after DONE, required done=0 d=63",
               bus8.done, bus8.d);
    end
  endtask

  task automatic test_borrow;
    logic [7:0] av [3] = '{8'd5, 8'h00, 8'h80};
    logic [7:0] bv [3] = '{8'd9, 8'hFF, 8'h01};
    int n;
    int nbusy;
    bit ok;
    exp8_t e;
    for (int i = 0; i < 3; i++) begin
      start_op8(av[i], bv[i]);
      wait_done8(n, nbusy, ok);
      e = exp8_q.pop_front();
      checks++;
      if (!ok || {bus8.d, bus8.bo, bus8.ov} !== {e.d, e.bo, e.ov}) begin
        errors++;
        $display("FAIL borrow_%0d: a=%h b=%h got d=%h bo=%b ov=%b (done=%0b), required d=%h bo=%b ov=%b",
                 i, av[i], bv[i], bus8.d, bus8.bo, bus8.ov, ok, e.d, e.bo, e.ov);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    int nbusy;
    bit ok;
    exp8_t e;
    int seen_done;
    // Aborted op: no expectation is queued for it.
    bus8.a     = 8'd50;
    bus8.b     = 8'd20;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus8.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_busy: busy=%b in 4th shift cycle, required 1", bus8.busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus8.busy, bus8.done, bus8.d, bus8.bo, bus8.ov} !== 12'h000) begin
      errors++;
      $display("FAIL mid_reset_clear: busy=%b done=%b d=%h bo=%b ov=%b, required all zero",
               bus8.busy, bus8.done, bus8.d, bus8.bo, bus8.ov);
    end
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL mid_reset_no_done: %0d active cycles after abort, required 0", seen_done);
    end
    // start and rst on the same edge: reset must win.
    rst        = 1'b1;
    bus8.a     = 8'd1;
    bus8.b     = 8'd1;
    bus8.start = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    bus8.start = 1'b0;
    checks++;
    if (bus8.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_beats_start: busy=%b, required 0", bus8.busy);
    end
    @(negedge clk);
    start_op8(8'd7, 8'd3);
    wait_done8(n, nbusy, ok);
    e = exp8_q.pop_front();
    checks++;
    if (!ok || {bus8.d, bus8.bo, bus8.ov} !== {e.d, e.bo, e.ov}) begin
      errors++;
      $display("FAIL after_reset_op: d=%0d bo=%b ov=%b (done=%0b), required d=%0d bo=%b ov=%b",
               bus8.d, bus8.bo, bus8.ov, ok, e.d, e.bo, e.ov);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_protect;
    exp8_t e;
    bus8.a     = 8'h3C;
    bus8.b     = 8'h5A;
    bus8.start = 1'b1;
    exp8_q.push_back(ref8(8'h3C, 8'h5A));
    // Hammer start and operands on every shift edge; all must be ignored.
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus8.start = k[0];
      bus8.a     = (k == 1) ? 8'hFF : 8'($urandom);
      bus8.b     = (k == 1) ? 8'h00 : 8'($urandom);
    end
    @(negedge clk);
    bus8.start = 1'b0;
    e = exp8_q.pop_front();
    checks++;
    if (bus8.done !== 1'b1 || {bus8.d, bus8.bo, bus8.ov} !== {e.d, e.bo, e.ov}) begin
      errors++;
      $display("FAIL busy_protect: done=%b d=%h bo=%b ov=%b, required done=1 d=%h bo=%b ov=%b",
               bus8.done, bus8.d, bus8.bo, bus8.ov, e.d, e.bo, e.ov);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int n;
    int nbusy;
    bit ok;
    exp8_t e;
    start_op8(8'd10, 8'd3);
    wait_done8(n, nbusy, ok);
    e = exp8_q.pop_front();
    checks++;
    if (!ok || {bus8.d, bus8.bo, bus8.ov} !== {e.d, e.bo, e.ov}) begin
      errors++;
      $display("FAIL b2b_first: d=%0d bo=%b (done=%0b), required d=%0d bo=%b",
               bus8.d, bus8.bo, ok, e.d, e.bo);
    end
    // Start issued during the DONE cycle itself.
    start_op8(8'd200, 8'd200);
    wait_done8(n, nbusy, ok);
    e = exp8_q.pop_front();
    checks++;
    if (!ok || n != 9 || {bus8.d, bus8.bo, bus8.ov} !== {e.d, e.bo, e.ov}) begin
      errors++;
      $display("FAIL b2b_second: done at %0d (found=%0b) d=%0d bo=%b ov=%b, required done at 9 d=%0d bo=%b ov=%b",
               n, ok, bus8.d, bus8.bo, bus8.ov, e.d, e.bo, e.ov);
    end
    @(negedge clk);
  endtask

  task automatic test_exhaustive_w4;
    exp4_t e;
    bit ok;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        bus4.a     = 4'(a);
        bus4.b     = 4'(b);
        bus4.start = 1'b1;
        exp4_q.push_back(ref4(a, b));
        @(negedge clk);
        bus4.start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
          if (k > 0) @(negedge clk);
          if (bus4.done === 1'b1) begin
            ok = 1'b1;
            break;
          end
        end
        e = exp4_q.pop_front();
        checks++;
        if (!ok || {bus4.d, bus4.bo, bus4.ov} !== {e.d, e.bo, e.ov}) begin
          errors++;
          $display("FAIL exhaustive_w4 a=%0d b=%0d: d=%h bo=%b ov=%b (done=%0b), required d=%h bo=%b ov=%b",
                   a, b, bus4.d, bus4.bo, bus4.ov, ok, e.d, e.bo, e.ov);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    rst4       = 1'b1;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus4.start = 1'b0;
    bus4.a     = '0;
    bus4.b     = '0;
    test_reset();
    test_basic();
    test_borrow();
    test_reset_mid();
    test_busy_protect();
    test_back_to_back();
    test_exhaustive_w4();
    checks++;
    if (exp8_q.size() != 0 || exp4_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0/0",
               exp8_q.size(), exp4_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit unsigned subtractor that computes d = a - b.
- Built around one full_subtractor cell instance, with ports a, b, bi, d, bo.
- Feeds the cell one bit pair per clock, LSB first, and registers the cell's borrow-out back into bi for the next bit.
- Sits directly on top of the full_subtractor cell and presents the multi-bit result upstream through a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a subtraction; sampled only when busy=0.
- a  input  WIDTH  minuend; captured on the accepting edge only.
- b  input  WIDTH  subtrahend; captured on the accepting edge only.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; d, bo and ov are valid and updated.
- d  output  WIDTH  registered difference (a - b) mod 2^WIDTH.
- bo  output  1  registered final borrow; 1 iff a < b unsigned.
- ov  output  1  registered two's-complement overflow of signed a - b.

Behaviour:
- Reset: applies on any edge with rst=1, regardless of state.
  - State goes to IDLE.
  - busy=0, done=0, d=0, bo=0, ov=0.
  - Internal borrow register, bit counter and shift registers are cleared.
  - Reset mid-operation aborts the operation; no done is issued for it.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: latch a and b into shift registers, clear borrow to 0, clear count to 0, go to SHIFT.
- SHIFT:
  - busy=1.
  - Each cycle drives the cell with a_sr[0], b_sr[0] and bi=borrow.
  - On each edge:
    - Cell d is shifted into the result register at the MSB end (result_sr shifts right).
    - borrow <= cell bo.
    - a_sr and b_sr shift right.
    - count increments.
  - After exactly WIDTH SHIFT cycles (on the edge where count=WIDTH-1), go to DONE and load outputs:
    - d <= completed difference.
    - bo <= final cell bo.
    - ov <= (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]), computed from the latched operand MSBs.
- DONE:
  - done=1, busy=0, held for exactly one cycle.
  - Next state is IDLE.
  - If start=1 in DONE, the new operands are accepted as in IDLE and the next state is SHIFT instead (back-to-back operation).
- Latency: start accepted on edge E0, done high in the cycle following edge E(WIDTH).
  - This is WIDTH+1 cycles from the start cycle to the done cycle.
  - Throughput is one result per WIDTH+1 cycles.
- Output hold:
  - d, bo and ov change only on the edge entering DONE.
  - They hold their value through IDLE and through a following operation until its own DONE.
- start while busy=1 is ignored; it is neither queued nor allowed to corrupt the latched operands.
- Changes on a and b after acceptance have no effect on the result.
- Wrap-around: a result below 0 wraps modulo 2^WIDTH, with bo=1.
- start and rst high on the same edge: rst wins.

Test Plan:
- Reset and idle: rst high 2 cycles, then a=8'h55, b=8'h11, start=0 for 20 cycles -> busy=0, done=0, d=0, bo=0, ov=0 throughout.
- Basic: a=8'd100, b=8'd37, start pulse -> busy=1 for 8 cycles, then done one cycle with d=8'd63, bo=0, ov=0; done exactly 9 cycles after the start cycle.
- Borrow and wrap:
  - a=8'd5, b=8'd9 -> d=8'hFC, bo=1, ov=0.
  - a=8'h00, b=8'hFF -> d=8'h01, bo=1.
  - a=8'h80, b=8'h01 -> d=8'h7F, bo=0, ov=1.
- Busy protection and back-to-back:
  - During busy, pulse start with a=8'hFF, b=8'h00 and toggle a/b every cycle -> first result unchanged.
  - start held high in the DONE cycle with a=8'd200, b=8'd200 -> second done 9 cycles later with d=0, bo=0.
- Reset mid-operation: start a=8'd50, b=8'd20; assert rst on the 4th SHIFT cycle -> busy=0, d=0, no done pulse; next op a=8'd7, b=8'd3 -> d=8'd4.
- Exhaustive compare: WIDTH=4, all 256 (a, b) pairs run sequentially -> each d == (a-b)&4'hF, bo == (a<b), ov matches the signed-overflow reference.
